// File: rtl/fifo_uart_tx.sv
// Byte-FIFO fed 8N1 UART transmitter: pops one byte from an upstream FIFO,
// frames it as start + 8 data bits (LSB first) + stop, CLK_DIV clocks per bit.
module fifo_uart_tx #(
  parameter int CLK_DIV = 434
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_data,
  output logic       fifo_rd,
  output logic       tx,
  output logic       busy,
  output logic       tx_done
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] CNT_PRE = CW'(CLK_DIV - 2);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  typedef enum logic [2:0] {
    IDLE,
    POP,
    LOAD,
    START,
    DATA,
    STOP
  } state_e;

  state_e         state_q;
  logic [CW-1:0]  cnt_q;
  logic [2:0]     bit_q;
  logic [7:0]     shift_q;
  logic           tx_q;
  logic           tx_done_q;

  // The pop strobe is gated by reset so a held reset never drains the FIFO.
  assign fifo_rd = reset && (state_q == IDLE) && !fifo_empty;
  // Busy covers the pop cycle as well, so back-to-back frames keep it high.
  assign busy    = (state_q != IDLE) || fifo_rd;
  assign tx      = tx_q;
  assign tx_done = tx_done_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      tx_q      <= 1'b1;
      tx_done_q <= 1'b0;
    end else begin
      tx_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          tx_q  <= 1'b1;
          cnt_q <= '0;
          bit_q <= '0;
          if (!fifo_empty) state_q <= POP;
        end
        POP: begin
          state_q <= LOAD;
        end
        LOAD: begin
          shift_q <= fifo_data;
          cnt_q   <= '0;
          bit_q   <= '0;
          tx_q    <= 1'b0;
          state_q <= START;
        end
        START: begin
          if (cnt_q == CNT_MAX) begin
            cnt_q   <= '0;
            tx_q    <= shift_q[0];
            state_q <= DATA;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        // tx is loaded one clock ahead, so the next bit comes from shift_q[1].
        DATA: begin
          if (cnt_q == CNT_MAX) begin
            cnt_q   <= '0;
            shift_q <= shift_q >> 1;
            if (bit_q == 3'd7) begin
              tx_q    <= 1'b1;
              state_q <= STOP;
            end else begin
              bit_q <= bit_q + 3'd1;
              tx_q  <= shift_q[1];
            end
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        STOP: begin
          tx_q <= 1'b1;
          if (cnt_q == CNT_PRE) tx_done_q <= 1'b1;
          if (cnt_q == CNT_MAX) begin
            cnt_q   <= '0;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        default: begin
          tx_q    <= 1'b1;
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule
